// File: rtl/dnn_infer_seq.sv
// -----------------------------------------------------------------------------
// dnn_infer_seq
//
// Inference sequencer for the fixed-point ReLU MNIST engine.
// 1. Takes one image as a valid/ready pixel stream and writes pixel k to
//    ADDR_BASE_A+k in the engine's activation memory.
// 2. Pulses the engine reset, then the engine start.
// 3. Waits for done and snapshots the ten class scores.
// 4. Runs a 10-cycle signed argmax scan.
// 5. Presents the winning class and its score on a valid/ready result port.
//
// Optional feature, controlled by the macro DNN_SEQ_TIMEOUT_EN:
//   defined   - a watchdog limits WAIT to TIMEOUT_CYC cycles. On expiry it
//               sets the sticky err flag and returns class 4'hF with score 0.
//   undefined - WAIT never times out, err is constant 0, and no counter is
//               built.
//
// Ports
//   clk        : clock; all logic is on the rising edge
//   rst        : asynchronous reset, active low
//   in_valid   : pixel valid          in_ready : pixel ready (IDLE/LOAD)
//   in_data    : pixel value
//   wr_en      : registered memory write strobe
//   wr_addr    : registered memory write address
//   wr_data    : registered memory write data
//   dnn_reset  : one-cycle engine reset pulse
//   dnn_start  : one-cycle engine start pulse
//   dnn_done   : engine done level, sampled only in WAIT
//   dnn_out    : ten packed signed class scores, class i at [i*DATA_WIDTH +: DATA_WIDTH]
//   res_valid  : result valid         res_ready : result ready
//   res_class  : argmax index (4'hF after a timeout)
//   res_score  : winning score
//   busy       : high in every state except IDLE
//   err        : sticky timeout flag
// -----------------------------------------------------------------------------
module dnn_infer_seq #(
    parameter int                    DATA_WIDTH  = 3,
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = '0,
    parameter int                    IMG_WORDS   = 400,
    parameter int                    TIMEOUT_CYC = 200000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     wr_en,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     dnn_reset,
    output logic                     dnn_start,
    input  logic                     dnn_done,
    input  logic [10*DATA_WIDTH-1:0] dnn_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [3:0]               res_class,
    output logic [DATA_WIDTH-1:0]    res_score,
    output logic                     busy,
    output logic                     err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RSTP,
        S_START,
        S_WAIT,
        S_SCAN,
        S_RESULT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] C_LAST_PIX = ADDR_WIDTH'(IMG_WORDS - 1);

    state_t                         r_state;
    state_t                         w_state_next;
    logic [ADDR_WIDTH-1:0]          r_cnt;
    logic                           r_wr_en;
    logic [ADDR_WIDTH-1:0]          r_wr_addr;
    logic [DATA_WIDTH-1:0]          r_wr_data;
    logic signed [DATA_WIDTH-1:0]   r_snap [0:9];
    logic signed [DATA_WIDTH-1:0]   r_best;
    logic [3:0]                     r_best_idx;
    logic [3:0]                     r_scan_idx;
    logic                           r_err;
    logic signed [DATA_WIDTH-1:0]   w_cand;
    logic                           w_in_ready;
    logic                           w_accept;
    logic                           w_timeout;
    logic                           w_dnn_reset;
    logic                           w_dnn_start;
    logic                           w_res_valid;
    logic                           w_busy;

    // Watchdog on the WAIT state
`ifdef DNN_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_wait_cnt;

    // The counter holds at zero outside WAIT, so it restarts on every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Done in the same cycle as expiry still counts as a normal completion.
    assign w_timeout = (r_state == S_WAIT) && !dnn_done &&
                       (r_wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
    // No watchdog in this build: the expression folds to constant 0.
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    // Reset is folded in so that in_ready reads 0 while rst is held low.
    assign w_accept = in_valid & w_in_ready;
    assign w_cand   = r_snap[r_scan_idx];

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and outputs
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_dnn_reset  = 1'b0;
        w_dnn_start  = 1'b0;
        w_res_valid  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE, S_LOAD: begin
                w_in_ready = rst;
                w_busy     = (r_state != S_IDLE);
                if (in_valid && rst) begin
                    w_state_next = (r_cnt == C_LAST_PIX) ? S_RSTP : S_LOAD;
                end
            end
            S_RSTP: begin
                w_dnn_reset  = 1'b1;
                w_state_next = S_START;
            end
            S_START: begin
                w_dnn_start  = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (dnn_done) begin
                    w_state_next = S_SCAN;
                end else if (w_timeout) begin
                    w_state_next = S_RESULT;
                end
            end
            S_SCAN: begin
                if (r_scan_idx == 4'd9) begin
                    w_state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                w_res_valid = 1'b1;
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Snapshot of the class outputs, captured on the cycle done is seen in WAIT
    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_snap
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_snap[gi] <= '0;
                end else if (r_state == S_WAIT && dnn_done) begin
                    r_snap[gi] <= dnn_out[gi*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    endgenerate

    // Write path, pixel counter, argmax scan and error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_scan_idx <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= ADDR_BASE_A + r_cnt;
                r_wr_data <= in_data;
                r_cnt     <= (r_cnt == C_LAST_PIX) ? '0 : r_cnt + 1'b1;
                if (r_state == S_IDLE) begin
                    r_err <= 1'b0;
                end
            end
            case (r_state)
                S_WAIT: begin
                    if (dnn_done) begin
                        // Seed with class 0. Index 0 is then compared against
                        // itself on the first scan cycle and changes nothing.
                        r_best     <= dnn_out[DATA_WIDTH-1:0];
                        r_best_idx <= 4'd0;
                        r_scan_idx <= 4'd0;
                    end else if (w_timeout) begin
                        r_err      <= 1'b1;
                        r_best     <= '0;
                        r_best_idx <= 4'hF;
                    end
                end
                S_SCAN: begin
                    // Strictly greater: ties keep the lower index.
                    if (w_cand > r_best) begin
                        r_best     <= w_cand;
                        r_best_idx <= r_scan_idx;
                    end
                    r_scan_idx <= r_scan_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign dnn_reset = w_dnn_reset;
    assign dnn_start = w_dnn_start;
    assign res_valid = w_res_valid;
    assign res_class = r_best_idx;
    assign res_score = r_best;
    assign busy      = w_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_dnn_infer_seq.sv
// -----------------------------------------------------------------------------
// tb_dnn_infer_seq
//
// Self-checking bench for dnn_infer_seq.
// - Streams images into the DUT and plays the engine's part on dnn_done/dnn_out.
// - Compares writes, pulse timing, result latency and argmax against a plain
//   reference model.
// - The timeout scenario is compiled in when DNN_SEQ_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_dnn_infer_seq;

    localparam int DW  = 3;
    localparam int AW  = 16;
    localparam int IMG = 400;
    localparam int TMO = 100;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_data = '0;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             dnn_reset;
    logic             dnn_start;
    logic             dnn_done = 1'b0;
    logic [10*DW-1:0] dnn_out;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [3:0]       res_class;
    logic [DW-1:0]    res_score;
    logic             busy;
    logic             err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int outs [10];      // engine class scores, -4..3
    int exp_pix [IMG];  // pixels sent for the current image

    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];
    int rstp_q[$];
    int start_q[$];

    dnn_infer_seq #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .IMG_WORDS  (IMG),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dnn_reset(dnn_reset),
        .dnn_start(dnn_start),
        .dnn_done (dnn_done),
        .dnn_out  (dnn_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_class(res_class),
        .res_score(res_score),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // cyc names the cycle that starts at each rising edge
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        dnn_out = '0;
        for (int i = 0; i < 10; i++) dnn_out[i*DW +: DW] = outs[i][DW-1:0];
    end

    // Observe writes and pulses in the middle of each cycle
    always @(negedge clk) begin
        if (wr_en) begin
            wr_addr_q.push_back(int'(wr_addr));
            wr_data_q.push_back(int'(wr_data));
            wr_cyc_q.push_back(cyc);
        end
        if (dnn_reset) rstp_q.push_back(cyc);
        if (dnn_start) start_q.push_back(cyc);
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "global timeout");
    end

    // Reference argmax: first index holding the largest signed score
    function automatic void ref_argmax(output int cls, output int score);
        cls = 0;
        for (int i = 1; i < 10; i++) if (outs[i] > outs[cls]) cls = i;
        score = outs[cls];
    endfunction

    // Tasks start and end at one time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_image(input int start_k, input int stop_k, input int gap,
                              input bit pattern, output int t_last);
        int  n;
        int  d;
        bit  hs;
        t_last = -1;
        for (int k = start_k; k < stop_k; k++) begin
            d = pattern ? (k % 4) : int'($urandom_range(0, 7));
            exp_pix[k] = d;
            in_valid = 1'b1;
            in_data  = d[DW-1:0];
            hs = 1'b0;
            n  = 0;
            while (!hs && n < 50) begin
                @(negedge clk);
                if (in_ready) begin hs = 1'b1; t_last = cyc; end
                else n++;
                @(posedge clk); #1;
            end
            if (!hs) begin
                checks++; errors++;
                $display("FAIL in_ready_wait pixel %0d: in_ready stayed 0, required 1", k);
                in_valid = 1'b0;
                return;
            end
            if (gap > 0) begin
                in_valid = 1'b0;
                tick(gap);
            end
        end
        in_valid = 1'b0;
    endtask

    // Engine done, result latency, argmax, result hold and handshake
    task automatic run_result(input string name, input int stall);
        int d_cyc, rv, n, bad, ec, es, hold_c, hold_s;
        ref_argmax(ec, es);
        dnn_done = 1'b1;
        @(negedge clk); d_cyc = cyc;
        @(posedge clk); #1;
        dnn_done = 1'b0;
        rv = -1; n = 0;
        while (rv < 0 && n < 40) begin
            @(negedge clk);
            if (res_valid) rv = cyc;
            else n++;
            @(posedge clk); #1;
        end
        checks++;
        if (rv !== d_cyc + 11) begin
            errors++;
            $display("FAIL %s_latency: res_valid at done+%0d, required done+11", name, rv - d_cyc);
            return;
        end
        checks++;
        if (int'(res_class) !== ec) begin
            errors++;
            $display("FAIL %s_class: got %0d, required %0d", name, res_class, ec);
        end
        checks++;
        if (int'($signed(res_score)) !== es) begin
            errors++;
            $display("FAIL %s_score: got %0d, required %0d", name, $signed(res_score), es);
        end
        if (stall > 0) begin
            bad = 0;
            hold_c = int'(res_class);
            hold_s = int'(res_score);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (!res_valid || in_ready || int'(res_class) != hold_c ||
                    int'(res_score) != hold_s) bad++;
                @(posedge clk); #1;
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL %s_hold: %0d unstable cycles during stall, required 0", name, bad);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, res_valid} !== 3'b100) begin
            errors++;
            $display("FAIL %s_after_hs: in_ready/busy/res_valid=%b, required 100", name,
                     {in_ready, busy, res_valid});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        @(negedge clk);
        checks++;
        if ({in_ready, busy, wr_en, dnn_reset, dnn_start, res_valid, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 0000000",
                     {in_ready, busy, wr_en, dnn_reset, dnn_start, res_valid, err});
        end
        checks++;
        if ({res_class, res_score, wr_addr} !== '0) begin
            errors++;
            $display("FAIL reset_values: class=%0d score=%0d addr=%0d, required 0",
                     res_class, res_score, wr_addr);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_scan();
        int wb, rb, sb, tl, bad;
        wb = wr_addr_q.size(); rb = rstp_q.size(); sb = start_q.size();
        send_image(0, IMG, 0, 1'b1, tl);
        tick(5);
        checks++;
        if (wr_addr_q.size() - wb !== IMG) begin
            errors++;
            $display("FAIL load_write_count: got %0d, required %0d", wr_addr_q.size() - wb, IMG);
        end else begin
            bad = 0;
            for (int k = 0; k < IMG; k++)
                if (wr_addr_q[wb+k] != k || wr_data_q[wb+k] != exp_pix[k]) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL load_write_contents: %0d bad writes, required 0", bad);
            end
            checks++;
            if (wr_cyc_q[wb+IMG-1] !== tl + 1) begin
                errors++;
                $display("FAIL load_last_write: at T+%0d, required T+1", wr_cyc_q[wb+IMG-1] - tl);
            end
        end
        checks++;
        if (rstp_q.size() - rb !== 1 || rstp_q[rb] !== tl + 1) begin
            errors++;
            $display("FAIL load_dnn_reset: %0d pulses, first at T+%0d, required 1 at T+1",
                     rstp_q.size() - rb, (rstp_q.size() > rb) ? rstp_q[rb] - tl : -1);
        end
        checks++;
        if (start_q.size() - sb !== 1 || start_q[sb] !== tl + 2) begin
            errors++;
            $display("FAIL load_dnn_start: %0d pulses, first at T+%0d, required 1 at T+2",
                     start_q.size() - sb, (start_q.size() > sb) ? start_q[sb] - tl : -1);
        end
        outs = '{0, 1, -2, 3, 1, -4, 2, 3, 0, -1};
        run_result("tie_low", 0);
    endtask

    task automatic test_all_equal_stall();
        int tl;
        send_image(0, IMG, 0, 1'b0, tl);
        tick(4);
        for (int i = 0; i < 10; i++) outs[i] = -4;
        run_result("all_neg4", 20);
    endtask

    task automatic test_done_ignored();
        int sb;
        sb = start_q.size();
        dnn_done = 1'b1;
        tick(3);
        dnn_done = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || start_q.size() !== sb) begin
            errors++;
            $display("FAIL done_in_idle: busy=%b starts=%0d, required busy=0 starts=0",
                     busy, start_q.size() - sb);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int tl;
        for (int it = 0; it < 4; it++) begin
            send_image(0, IMG, int'($urandom_range(0, 1)), 1'b0, tl);
            for (int i = 0; i < 10; i++) outs[i] = int'($urandom_range(0, 7)) - 4;
            tick(int'($urandom_range(3, 20)));
            run_result("random", it == 1 ? 5 : 0);
        end
    endtask

    task automatic test_reset_mid();
        int wb, tl, bad;
        wb = wr_addr_q.size();
        send_image(0, 200, 2, 1'b0, tl);
        in_valid = 1'b1;
        in_data  = 3'd5;
        #2;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, wr_en, dnn_reset, dnn_start, res_valid, err} !== 7'b0 ||
            {res_class, res_score} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: flags=%b class=%0d score=%0d, required all 0",
                     {in_ready, busy, wr_en, dnn_reset, dnn_start, res_valid, err},
                     res_class, res_score);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tick(2);
        checks++;
        if (wr_addr_q.size() - wb !== 200) begin
            errors++;
            $display("FAIL midreset_writes: got %0d writes, required 200", wr_addr_q.size() - wb);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
        @(posedge clk); #1;
        wb = wr_addr_q.size();
        send_image(0, IMG, 1, 1'b0, tl);
        tick(4);
        checks++;
        if (wr_addr_q.size() - wb !== IMG) begin
            errors++;
            $display("FAIL reload_write_count: got %0d, required %0d", wr_addr_q.size() - wb, IMG);
        end else begin
            bad = 0;
            for (int k = 0; k < IMG; k++)
                if (wr_addr_q[wb+k] != k || wr_data_q[wb+k] != exp_pix[k]) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL reload_write_contents: %0d bad writes (first addr %0d), required 0",
                         bad, wr_addr_q[wb]);
            end
        end
        outs = '{-3, 2, -1, 2, 3, -4, 3, 0, 1, -2};
        run_result("reload", 0);
    endtask

    task automatic test_timeout();
        int tl;
        send_image(0, IMG, 0, 1'b0, tl);
`ifdef DNN_SEQ_TIMEOUT_EN
        begin
            int rv, n;
            rv = -1; n = 0;
            while (rv < 0 && n < 3 * TMO) begin
                @(negedge clk);
                if (res_valid) rv = cyc;
                else n++;
                @(posedge clk); #1;
            end
            checks++;
            if (rv !== tl + 3 + TMO) begin
                errors++;
                $display("FAIL timeout_latency: res_valid at T+%0d, required T+%0d", rv - tl, 3 + TMO);
            end
            checks++;
            if ({err, res_class, res_score} !== {1'b1, 4'hF, 3'd0}) begin
                errors++;
                $display("FAIL timeout_result: err=%b class=%h score=%0d, required 1 F 0",
                         err, res_class, res_score);
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL timeout_err_sticky: err=%b in_ready=%b, required 1 1", err, in_ready);
            end
            @(posedge clk); #1;
            send_image(0, 1, 0, 1'b0, tl);
            @(negedge clk);
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_err_clear: err=%b, required 0", err);
            end
            @(posedge clk); #1;
            send_image(1, IMG, 0, 1'b0, tl);
            tick(3);
            outs = '{1, 1, 2, -1, 0, 2, -3, 1, 0, 2};
            run_result("after_timeout", 0);
        end
`else
        tick(3 * TMO);
        @(negedge clk);
        checks++;
        if ({busy, res_valid, err} !== 3'b100) begin
            errors++;
            $display("FAIL no_timeout_wait: busy/res_valid/err=%b, required 100",
                     {busy, res_valid, err});
        end
        @(posedge clk); #1;
        outs = '{1, 1, 2, -1, 0, 2, -3, 1, 0, 2};
        run_result("long_wait", 0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 10; i++) outs[i] = 0;
        @(posedge clk); #1;
        test_reset();
        test_load_scan();
        test_all_equal_stall();
        test_done_ignored();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dnn_infer_seq.md
# dnn_infer_seq

Inference sequencer for the fixed-point ReLU MNIST engine. It accepts one image as a valid/ready pixel stream and writes it into the activation region of the engine's memory. It then resets and starts the engine, waits for done, and scans the ten class outputs for a signed argmax. The winning class and its score are returned on a valid/ready result port; the block sits between the host/testbench stream and the dnn_relu_fix instance.

## Interface
- DATA_WIDTH, 3, width of pixels and class scores (signed)
- ADDR_WIDTH, 16, memory address width
- ADDR_BASE_A, 16'h0000, first activation address; pixel k is written to ADDR_BASE_A+k
- IMG_WORDS, 400, pixels per image (range 1..2^ADDR_WIDTH-ADDR_BASE_A)
- TIMEOUT_CYC, 200000, watchdog limit in cycles (used only with DNN_SEQ_TIMEOUT_EN)
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel ready
- in_data  in  DATA_WIDTH  pixel value
- wr_en  out  1  memory write strobe
- wr_addr  out  ADDR_WIDTH  memory write address
- wr_data  out  DATA_WIDTH  memory write data
- dnn_reset  out  1  one-cycle engine reset pulse
- dnn_start  out  1  one-cycle engine start pulse
- dnn_done  in  1  engine done level
- dnn_out  in  10 x DATA_WIDTH signed  engine class outputs [9:0]
- res_valid  out  1  result valid
- res_ready  in  1  result ready
- res_class  out  4  argmax index 0..9; 4'hF on timeout
- res_score  out  DATA_WIDTH signed  winning score
- busy  out  1  high in every state except IDLE
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, LOAD, RSTP, START, WAIT, SCAN, RESULT.
- IDLE/LOAD: in_ready=1. Each handshake (in_valid&in_ready) writes the pixel to the next address.
  - The first accept moves IDLE to LOAD; the pixel counter runs 0..IMG_WORDS-1.
  - Accepting pixel IMG_WORDS-1 moves to RSTP. For IMG_WORDS=1, IDLE goes directly to RSTP.
- RSTP: dnn_reset=1 for one cycle, then START.
- START: dnn_start=1 for one cycle, then WAIT.
- WAIT: dnn_done is sampled only in this state.
  - On dnn_done=1, all ten dnn_out values are captured into a snapshot register, then SCAN.
- SCAN: 10 cycles, index i=0..9, one compare per cycle.
  - Best starts at snapshot[0] with index 0.
  - A strictly greater signed value replaces best, so ties keep the lower index.
- RESULT: res_valid=1; res_class and res_score are held stable until res_ready. The handshake returns to IDLE.
- err sets on timeout and clears on the first pixel accept of the next image.
- Memory writes never overlap engine reads: the engine is started only after the last write has retired.

## Timing
- Reset values: in_ready=0 while rst is low and 1 in the first IDLE cycle after release. All other outputs are 0 (res_class=0, res_score=0, err=0) and the state is IDLE.
- wr_en/wr_addr/wr_data are registered: the write happens the cycle after the handshake. The last write coincides with the RSTP cycle.
- Last pixel accepted at cycle T: dnn_reset at T+1, dnn_start at T+2, WAIT from T+3.
- dnn_done sampled high at cycle D: snapshot at D, SCAN D+1..D+10, res_valid at D+11.
- in_ready is 0 in RSTP through RESULT. After a result handshake at cycle R, in_ready=1 at R+1.
- dnn_done high outside WAIT is ignored. A stalled in_valid holds LOAD indefinitely, with no timeout.
- Reset asserted mid-operation returns to IDLE immediately: no pending write, no start pulse, partial image discarded.

## Configuration
- DNN_SEQ_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT, cleared on entry.
  - Reaching TIMEOUT_CYC without dnn_done sets err and skips SCAN, going to RESULT with res_class=4'hF and res_score=0.
- DNN_SEQ_TIMEOUT_EN undefined: WAIT has no limit, err is tied 0 and no counter is built.

## Test plan
- Reset, IMG_WORDS=400, continuous in_valid with pixel k=k mod 4 -> 400 writes at addresses 0..399 with matching data; dnn_reset at T+1, dnn_start at T+2, each a single cycle.
- Engine model asserts done with out={0,1,-2,3,1,-4,2,3,0,-1} (index 0..9) -> res_class=3, res_score=3 (tie with index 7 resolved low), res_valid exactly 11 cycles after done.
- All outputs equal to -4 -> res_class=0, res_score=-4.
- Hold res_ready=0 for 20 cycles -> res_valid, res_class and res_score stable and in_ready=0; pull res_ready high -> in_ready=1 next cycle.
- Bubbly in_valid (1 of 3 cycles), then rst low at pixel 200 -> outputs at reset values; a full new image afterwards loads from address 0.
- With DNN_SEQ_TIMEOUT_EN, TIMEOUT_CYC=100 and no done -> err=1, res_class=4'hF, res_score=0; err clears on the next image's first accept.
